// File: rtl/vga_pkg.sv
// Shared constants for the VGA plot-port blocks: screen geometry, field widths,
// the 3-bit RGB palette and the rectangle plotter's FSM encoding.
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
   localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
   localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
   localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
   localparam logic [COLOUR_W-1:0] RED     = 3'b100;
   localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
   localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
   localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

   // Plotter FSM encoding; also visible on the top's dbg_state output.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DRAW = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/vga_raster_counter.sv
// Loadable row-major raster counter. On load it latches the start corner and the
// (non-zero) extent; each step advances one pixel, wrapping the column back to the
// start column and moving down a row. last flags the final pixel of the area.
module vga_raster_counter
   import vga_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic [X_W-1:0] x_start,
   input  logic [Y_W-1:0] y_start,
   input  logic [X_W-1:0] x_extent,
   input  logic [Y_W-1:0] y_extent,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   logic [X_W-1:0] x_base;
   logic [X_W-1:0] col;
   logic [Y_W-1:0] row;
   logic [X_W-1:0] col_last;
   logic [Y_W-1:0] row_last;

   // Position and offset counters; x/y hold their value whenever not stepping.
   always_ff @(posedge clock) begin
      if (reset) begin
         x        <= '0;
         y        <= '0;
         x_base   <= '0;
         col      <= '0;
         row      <= '0;
         col_last <= '0;
         row_last <= '0;
      end else if (load) begin
         x        <= x_start;
         y        <= y_start;
         x_base   <= x_start;
         col      <= '0;
         row      <= '0;
         col_last <= x_extent - X_W'(1);
         row_last <= y_extent - Y_W'(1);
      end else if (step) begin
         if (col == col_last) begin
            col <= '0;
            x   <= x_base;
            row <= row + Y_W'(1);
            y   <= y + Y_W'(1);
         end else begin
            col <= col + X_W'(1);
            x   <= x + X_W'(1);
         end
      end
   end

   assign last = (col == col_last) && (row == row_last);

endmodule

// File: rtl/vga_rect_plotter.sv
// Rectangle-fill pixel streamer for the VGA adapter plot port.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are
// both high; req_ready is high only while IDLE, and the request fields are latched
// on that edge only. After acceptance the block streams one pixel per clock (plot
// high, no gaps, no backpressure) and then pulses done for one cycle.
module vga_rect_plotter
   import vga_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [X_W-1:0]      req_x0,
   input  logic [Y_W-1:0]      req_y0,
   input  logic [X_W-1:0]      req_w,
   input  logic [Y_W-1:0]      req_h,
   input  logic [COLOUR_W-1:0] req_colour,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                done,
   output logic [1:0]          dbg_state
);

   localparam logic [X_W:0] SW_EXT = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SH_EXT = (Y_W+1)'(SCREEN_H);

   logic [1:0]   state;
   logic [X_W:0] x_room;
   logic [Y_W:0] y_room;
   logic [X_W:0] ew;
   logic [Y_W:0] eh;
   logic         area_nz;
   logic         accept;
   logic         last;

   // Clip the incoming request to the screen one bit wider than the fields, so
   // an off-screen origin or oversize extent can never wrap.
   always_comb begin
      x_room  = SW_EXT - {1'b0, req_x0};
      y_room  = SH_EXT - {1'b0, req_y0};
      ew      = '0;
      eh      = '0;
      if ({1'b0, req_x0} < SW_EXT)
         ew = ({1'b0, req_w} < x_room) ? {1'b0, req_w} : x_room;
      if ({1'b0, req_y0} < SH_EXT)
         eh = ({1'b0, req_h} < y_room) ? {1'b0, req_h} : y_room;
      area_nz = (ew != '0) && (eh != '0);
   end

   assign accept    = req_valid && req_ready;
   assign dbg_state = state;

   // Clipped extents never exceed the screen, so the top bit of ew/eh is zero.
   vga_raster_counter u_raster (
      .clock    (clock),
      .reset    (reset),
      .load     (accept && area_nz),
      .step     ((state == ST_DRAW) && !last),
      .x_start  (req_x0),
      .y_start  (req_y0),
      .x_extent (ew[X_W-1:0]),
      .y_extent (eh[Y_W-1:0]),
      .x        (x),
      .y        (y),
      .last     (last)
   );

   // Control FSM and registered handshake/strobe outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         plot      <= 1'b0;
         done      <= 1'b0;
         colour    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  req_ready <= 1'b0;
                  if (area_nz) begin
                     state  <= ST_DRAW;
                     plot   <= 1'b1;
                     colour <= req_colour;
                  end else begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end
               end
            end
            ST_DRAW: begin
               if (last) begin
                  state <= ST_FIN;
                  plot  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_FIN: begin
               state     <= ST_IDLE;
               done      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               plot      <= 1'b0;
               done      <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
